// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: MDop values,
// FSM states and the latency-class selector.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_div_class(md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing {HI,LO}.
// Accumulate path exists only with MUL_DIV_UNIT_MAC_EN defined.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MUL_DIV_UNIT_MAC_EN
    input  logic [2*WIDTH-1:0] acc,
`endif
    output logic [2*WIDTH-1:0] res
);

    localparam int W2 = 2 * WIDTH;

    logic signed [W2-1:0]    sa_ext;
    logic signed [W2-1:0]    sb_ext;
    logic [W2-1:0]           prod_s;
    logic [W2-1:0]           prod_u;
    logic [WIDTH-1:0]        min_val;
    logic [WIDTH-1:0]        bs_safe;
    logic [WIDTH-1:0]        bu_safe;
    logic [WIDTH-1:0]        q_u;
    logic [WIDTH-1:0]        r_u;
    logic signed [WIDTH-1:0] q_s;
    logic signed [WIDTH-1:0] r_s;
    logic                    div_zero;
    logic                    div_ovf;

    assign sa_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = sa_ext * sb_ext;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_zero = (b == '0);
    assign div_ovf  = (a == min_val) && (b == '1);

    // Keep the dividers away from the 0 and min/-1 corners
    assign bs_safe = (div_zero || div_ovf) ? WIDTH'(1) : b;
    assign bu_safe = div_zero ? WIDTH'(1) : b;

    assign q_u = a / bu_safe;
    assign r_u = a % bu_safe;
    assign q_s = $signed(a) / $signed(bs_safe);
    assign r_s = $signed(a) % $signed(bs_safe);

`ifdef MUL_DIV_UNIT_MAC_EN
    logic [W2-1:0] mac_addend;
    logic [W2-1:0] mac_sum;

    assign mac_addend = op[0] ? prod_u : prod_s;
    assign mac_sum    = op[1] ? (acc - mac_addend) : (acc + mac_addend);
`endif

    always_comb begin
        res = '0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (div_zero)
                    res = {a, {WIDTH{1'b1}}};
                else if (div_ovf)
                    res = {{WIDTH{1'b0}}, min_val};
                else
                    res = {r_s, q_s};
            end
            OP_DIVU: begin
                if (div_zero)
                    res = {a, {WIDTH{1'b1}}};
                else
                    res = {r_u, q_u};
            end
`ifdef MUL_DIV_UNIT_MAC_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: res = mac_sum;
`endif
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// MUL_DIV_UNIT_MAC_EN enables madd/maddu/msub/msubu.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cond_en,
    input  logic [2:0]       MDop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIwrite,
    input  logic             LOwrite,
    input  logic             flush,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    md_state_e          state_q;
    md_state_e          state_d;
    logic [4:0]         cnt_q;
    logic [4:0]         cnt_d;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] res;
    logic               op_legal;
    logic               cond_ok;
    logic               accept;
    logic               commit;
    logic               wr_ok;

`ifdef MUL_DIV_UNIT_MAC_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~MDop[2];
`endif

    // Conditional launch needs A strictly positive
    assign cond_ok = ~cond_en | (~A[WIDTH-1] & (|A));
    assign accept  = (state_q == S_IDLE) & start & ~flush
                   & op_legal & cond_ok;
    assign commit  = (state_q == S_RUN) & ~flush & (cnt_q == 5'd1);
    assign wr_ok   = (state_q == S_IDLE) & ~start & ~flush;
    assign Busy    = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = is_div_class(md_op_e'(MDop))
                            ? 5'(DIV_LAT) : 5'(MUL_LAT);
                end
            end
            S_RUN: begin
                if (flush || cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q <= md_op_e'(MDop);
                a_q  <= A;
                b_q  <= B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            {HI, LO} <= res;
        end else if (wr_ok) begin
            if (HIwrite) HI <= A;
            if (LOwrite) LO <= A;
        end
    end

    md_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
`ifdef MUL_DIV_UNIT_MAC_EN
        .acc ({HI, LO}),
`endif
        .res (res)
    );

endmodule
